// File: rtl/io_bridge.sv
// io_bridge: peripheral-side responder for the processor I/O port protocol.
// Every input and output port is decoupled from external logic by its own
// FIFO. The processor side never stalls; the external side uses valid/ready.
//
// Handshake semantics (all external ports): a word moves on a rising clk edge
// exactly when valid and ready are both 1 on that edge. Valid never depends on
// ready. Ready is forced low while rst is high, so no transfer completes during
// reset.
module io_bridge #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [NUBITS-1:0]         io_in,
    input  logic [$clog2(NUIOIN)-1:0] addr_in,
    input  logic                      req_in,
    input  logic [NUBITS-1:0]         io_out,
    input  logic [$clog2(NUIOOU)-1:0] addr_out,
    input  logic                      out_en,
    output logic                      itr,
    input  logic [NUIOIN*NUBITS-1:0]  ext_in_data,
    input  logic [NUIOIN-1:0]         ext_in_vld,
    output logic [NUIOIN-1:0]         ext_in_rdy,
    output logic [NUIOOU*NUBITS-1:0]  ext_out_data,
    output logic [NUIOOU-1:0]         ext_out_vld,
    input  logic [NUIOOU-1:0]         ext_out_rdy,
    output logic                      err_ovf,
    output logic                      err_udf
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;

    // Input FIFO state
    logic [NUBITS-1:0] in_mem_q [NUIOIN][FDEPTH];
    logic [PW-1:0]     in_wp_q  [NUIOIN];
    logic [PW-1:0]     in_rp_q  [NUIOIN];
    logic [CW-1:0]     in_cnt_q [NUIOIN];

    // Output FIFO state
    logic [NUBITS-1:0] out_mem_q [NUIOOU][FDEPTH];
    logic [PW-1:0]     out_wp_q  [NUIOOU];
    logic [PW-1:0]     out_rp_q  [NUIOOU];
    logic [CW-1:0]     out_cnt_q [NUIOOU];

    logic itr_q, itr_d;
    logic err_ovf_q, err_udf_q;

    logic [NUIOIN-1:0] in_push, in_pop, in_full, in_empty;
    logic [NUIOOU-1:0] out_push, out_pop, out_full, out_empty;
    logic              rd_err, wr_drop;

    // Input side: ready/full decode, processor read mux and pop selection
    always_comb begin
        in_push    = '0;
        in_pop     = '0;
        in_full    = '0;
        in_empty   = '0;
        ext_in_rdy = '0;
        io_in      = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            in_full[k]    = (in_cnt_q[k] == CW'(FDEPTH));
            in_empty[k]   = (in_cnt_q[k] == '0);
            ext_in_rdy[k] = !in_full[k] && !rst;
            in_push[k]    = ext_in_vld[k] && ext_in_rdy[k];
            // Reads see only stored words: a word pushed this edge is not poppable yet
            if (int'(addr_in) == k && !in_empty[k]) begin
                io_in     = in_mem_q[k][in_rp_q[k]];
                in_pop[k] = req_in;
            end
        end
        // Covers both an empty port and an out-of-range address
        rd_err = req_in && (in_pop == '0);
        // Interrupt on any port going from empty to one word this edge
        itr_d  = |(in_push & in_empty);
    end

    // Output side: valid/data presentation and processor write acceptance
    always_comb begin
        out_push     = '0;
        out_pop      = '0;
        out_full     = '0;
        out_empty    = '0;
        ext_out_vld  = '0;
        ext_out_data = '0;
        wr_drop      = 1'b0;
        for (int k = 0; k < NUIOOU; k++) begin
            out_full[k]  = (out_cnt_q[k] == CW'(FDEPTH));
            out_empty[k] = (out_cnt_q[k] == '0);
            ext_out_vld[k] = !out_empty[k];
            ext_out_data[k*NUBITS +: NUBITS] = out_mem_q[k][out_rp_q[k]];
            out_pop[k] = ext_out_vld[k] && ext_out_rdy[k];
            // A full FIFO still accepts a write if a slot frees on the same edge
            if (out_en && int'(addr_out) == k) begin
                if (!out_full[k] || out_pop[k]) begin
                    out_push[k] = 1'b1;
                end else begin
                    wr_drop = 1'b1;
                end
            end
        end
    end

    // Pointers, counts, interrupt pulse and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUIOIN; k++) begin
                in_wp_q[k]  <= '0;
                in_rp_q[k]  <= '0;
                in_cnt_q[k] <= '0;
            end
            for (int k = 0; k < NUIOOU; k++) begin
                out_wp_q[k]  <= '0;
                out_rp_q[k]  <= '0;
                out_cnt_q[k] <= '0;
            end
            itr_q     <= 1'b0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (in_push[k]) in_wp_q[k] <= in_wp_q[k] + 1'b1;
                if (in_pop[k])  in_rp_q[k] <= in_rp_q[k] + 1'b1;
                in_cnt_q[k] <= in_cnt_q[k] + CW'(in_push[k]) - CW'(in_pop[k]);
            end
            for (int k = 0; k < NUIOOU; k++) begin
                if (out_push[k]) out_wp_q[k] <= out_wp_q[k] + 1'b1;
                if (out_pop[k])  out_rp_q[k] <= out_rp_q[k] + 1'b1;
                out_cnt_q[k] <= out_cnt_q[k] + CW'(out_push[k]) - CW'(out_pop[k]);
            end
            itr_q <= itr_d;
            if (wr_drop) err_ovf_q <= 1'b1;
            if (rd_err)  err_udf_q <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because counts gate visibility
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUIOIN; k++) begin
            if (in_push[k]) in_mem_q[k][in_wp_q[k]] <= ext_in_data[k*NUBITS +: NUBITS];
        end
        for (int k = 0; k < NUIOOU; k++) begin
            if (out_push[k]) out_mem_q[k][out_wp_q[k]] <= io_out;
        end
    end

    assign itr     = itr_q;
    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed and randomized checks of io_bridge against a
// queue-based reference model of the port FIFOs.
module tb_io_bridge;
  localparam int NUBITS = 16;
  localparam int NUIOIN = 2;
  localparam int NUIOOU = 2;
  localparam int FDEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUBITS-1:0]        io_in;
  logic [0:0]               addr_in;
  logic                     req_in;
  logic [NUBITS-1:0]        io_out;
  logic [0:0]               addr_out;
  logic                     out_en;
  logic                     itr;
  logic [NUIOIN*NUBITS-1:0] ext_in_data;
  logic [NUIOIN-1:0]        ext_in_vld;
  logic [NUIOIN-1:0]        ext_in_rdy;
  logic [NUIOOU*NUBITS-1:0] ext_out_data;
  logic [NUIOOU-1:0]        ext_out_vld;
  logic [NUIOOU-1:0]        ext_out_rdy;
  logic                     err_ovf;
  logic                     err_udf;

  io_bridge #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst),
    .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
    .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
    .itr(itr),
    .ext_in_data(ext_in_data), .ext_in_vld(ext_in_vld), .ext_in_rdy(ext_in_rdy),
    .ext_out_data(ext_out_data), .ext_out_vld(ext_out_vld), .ext_out_rdy(ext_out_rdy),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [NUBITS-1:0] in_exp_q  [NUIOIN][$];
  logic [NUBITS-1:0] out_exp_q [NUIOOU][$];
  logic              m_itr, m_ovf, m_udf;
  logic [NUIOIN-1:0] m_push;

  task automatic model_reset;
    for (int k = 0; k < NUIOIN; k++) in_exp_q[k].delete();
    for (int k = 0; k < NUIOOU; k++) out_exp_q[k].delete();
    m_itr = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_push = '0;
  endtask

  function automatic logic [NUBITS-1:0] exp_io_in();
    int a = int'(addr_in);
    if (a < NUIOIN && in_exp_q[a].size() > 0) return in_exp_q[a][0];
    return '0;
  endfunction

  function automatic logic [NUIOIN-1:0] exp_in_rdy();
    logic [NUIOIN-1:0] r = '0;
    for (int k = 0; k < NUIOIN; k++) r[k] = (in_exp_q[k].size() < FDEPTH) && !rst;
    return r;
  endfunction

  function automatic logic [NUIOOU-1:0] exp_out_vld();
    logic [NUIOOU-1:0] v = '0;
    for (int k = 0; k < NUIOOU; k++) v[k] = (out_exp_q[k].size() > 0);
    return v;
  endfunction

  // Advance one clock edge, applying the queue rules to the inputs seen at
  // that edge, then return to a point midway through the low phase.
  task automatic step;
    logic [NUIOOU-1:0] opop;
    int a, osz;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_push = '0;
      m_itr  = 1'b0;
      for (int k = 0; k < NUIOIN; k++) begin
        m_push[k] = ext_in_vld[k] && (in_exp_q[k].size() < FDEPTH);
        if (m_push[k] && in_exp_q[k].size() == 0) m_itr = 1'b1;
      end
      for (int k = 0; k < NUIOOU; k++) opop[k] = (out_exp_q[k].size() > 0) && ext_out_rdy[k];
      if (req_in) begin
        a = int'(addr_in);
        if (a < NUIOIN && in_exp_q[a].size() > 0) void'(in_exp_q[a].pop_front());
        else m_udf = 1'b1;
      end
      for (int k = 0; k < NUIOIN; k++)
        if (m_push[k]) in_exp_q[k].push_back(ext_in_data[k*NUBITS +: NUBITS]);
      a = int'(addr_out);
      if (out_en && a < NUIOOU) begin
        osz = out_exp_q[a].size();
        if (osz < FDEPTH || opop[a]) begin
          if (opop[a]) void'(out_exp_q[a].pop_front());
          out_exp_q[a].push_back(io_out);
          opop[a] = 1'b0;
        end else begin
          m_ovf = 1'b1;
        end
      end
      for (int k = 0; k < NUIOOU; k++) if (opop[k]) void'(out_exp_q[k].pop_front());
    end
    @(negedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs;
    addr_in = '0; req_in = 1'b0; io_out = '0; addr_out = '0; out_en = 1'b0;
    ext_in_data = '0; ext_in_vld = '0; ext_out_rdy = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    step(); step();
    n_tests++; if (ext_in_rdy !== 2'b00) begin n_fail++; $display("FAIL rst_hold_rdy got %b exp %b", ext_in_rdy, 2'b00); end
    n_tests++; if (io_in !== 16'h0) begin n_fail++; $display("FAIL rst_hold_io_in got %h exp %h", io_in, 16'h0); end
    rst = 1'b0;
    step();
    n_tests++; if (ext_in_rdy !== 2'b11) begin n_fail++; $display("FAIL rst_release_rdy got %b exp %b", ext_in_rdy, 2'b11); end
    // build up state so the asynchronous reset has something to clear
    ext_in_vld = 2'b01; ext_in_data = {16'h0000, 16'h00C3};
    req_in = 1'b1; addr_in = 1'b1;
    out_en = 1'b1; addr_out = 1'b0; io_out = 16'h5555;
    step();
    clear_inputs();
    #1;
    n_tests++; if (err_udf !== 1'b1) begin n_fail++; $display("FAIL pre_rst_udf got %b exp %b", err_udf, 1'b1); end
    n_tests++; if (io_in !== 16'h00C3) begin n_fail++; $display("FAIL pre_rst_io_in got %h exp %h", io_in, 16'h00C3); end
    n_tests++; if (itr !== 1'b1) begin n_fail++; $display("FAIL pre_rst_itr got %b exp %b", itr, 1'b1); end
    // asynchronous assertion mid-cycle
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++; if (itr !== 1'b0) begin n_fail++; $display("FAIL async_itr got %b exp %b", itr, 1'b0); end
    n_tests++; if (err_udf !== 1'b0) begin n_fail++; $display("FAIL async_udf got %b exp %b", err_udf, 1'b0); end
    n_tests++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL async_ovf got %b exp %b", err_ovf, 1'b0); end
    n_tests++; if (ext_in_rdy !== 2'b00) begin n_fail++; $display("FAIL async_rdy got %b exp %b", ext_in_rdy, 2'b00); end
    n_tests++; if (ext_out_vld !== 2'b00) begin n_fail++; $display("FAIL async_vld got %b exp %b", ext_out_vld, 2'b00); end
    n_tests++; if (io_in !== 16'h0) begin n_fail++; $display("FAIL async_io_in got %h exp %h", io_in, 16'h0); end
    step();
    rst = 1'b0;
    step();
    n_tests++; if (ext_in_rdy !== 2'b11) begin n_fail++; $display("FAIL release_rdy got %b exp %b", ext_in_rdy, 2'b11); end
    n_tests++; if (io_in !== 16'h0) begin n_fail++; $display("FAIL release_io_in got %h exp %h", io_in, 16'h0); end
    n_tests++; if (ext_out_vld !== 2'b00) begin n_fail++; $display("FAIL release_vld got %b exp %b", ext_out_vld, 2'b00); end
  endtask

  task automatic test_input_path;
    do_reset();
    addr_in = 1'b1;
    ext_in_vld = 2'b10; ext_in_data = {16'h1234, 16'h0000};
    step();
    n_tests++; if (itr !== 1'b1) begin n_fail++; $display("FAIL in_itr_first got %b exp %b", itr, 1'b1); end
    n_tests++; if (io_in !== 16'h1234) begin n_fail++; $display("FAIL in_head1 got %h exp %h", io_in, 16'h1234); end
    ext_in_data = {16'h5678, 16'h0000};
    step();
    ext_in_vld = 2'b00;
    n_tests++; if (itr !== 1'b0) begin n_fail++; $display("FAIL in_itr_second got %b exp %b", itr, 1'b0); end
    n_tests++; if (io_in !== 16'h1234) begin n_fail++; $display("FAIL in_head1_hold got %h exp %h", io_in, 16'h1234); end
    req_in = 1'b1;
    step();
    n_tests++; if (io_in !== 16'h5678) begin n_fail++; $display("FAIL in_head2 got %h exp %h", io_in, 16'h5678); end
    n_tests++; if (itr !== 1'b0) begin n_fail++; $display("FAIL in_itr_quiet got %b exp %b", itr, 1'b0); end
    step();
    n_tests++; if (io_in !== 16'h0) begin n_fail++; $display("FAIL in_empty got %h exp %h", io_in, 16'h0); end
    n_tests++; if (err_udf !== 1'b0) begin n_fail++; $display("FAIL in_udf_early got %b exp %b", err_udf, 1'b0); end
    step();
    req_in = 1'b0;
    n_tests++; if (err_udf !== 1'b1) begin n_fail++; $display("FAIL in_udf_set got %b exp %b", err_udf, 1'b1); end
    step(); step();
    n_tests++; if (err_udf !== 1'b1) begin n_fail++; $display("FAIL in_udf_sticky got %b exp %b", err_udf, 1'b1); end
  endtask

  task automatic test_input_full;
    logic [15:0] word;
    do_reset();
    addr_in = 1'b0;
    ext_in_vld = 2'b01;
    word = 16'd1;
    for (int c = 0; c < 6; c++) begin
      ext_in_data[15:0] = word;
      step();
      if (m_push[0]) word = word + 16'd1;
      if (c == 3) begin
        n_tests++; if (ext_in_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL full_rdy_drop got %b exp %b", ext_in_rdy[0], 1'b0); end
      end
    end
    ext_in_data[15:0] = word;
    n_tests++; if (ext_in_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL full_rdy_hold got %b exp %b", ext_in_rdy[0], 1'b0); end
    n_tests++; if (io_in !== 16'd1) begin n_fail++; $display("FAIL full_head got %h exp %h", io_in, 16'd1); end
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    n_tests++; if (ext_in_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL full_rdy_rise got %b exp %b", ext_in_rdy[0], 1'b1); end
    step();
    ext_in_vld = 2'b00;
    n_tests++; if (ext_in_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL full_rdy_refill got %b exp %b", ext_in_rdy[0], 1'b0); end
    req_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (io_in !== 16'(i + 2)) begin n_fail++; $display("FAIL full_drain%0d got %h exp %h", i, io_in, 16'(i + 2)); end
      step();
    end
    req_in = 1'b0;
  endtask

  task automatic test_output_path;
    logic [15:0] wr [5];
    wr = '{16'hBEEF, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    do_reset();
    ext_out_rdy = 2'b00; out_en = 1'b1; addr_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      io_out = wr[i];
      step();
      if (i == 0) begin
        n_tests++; if (ext_out_vld[0] !== 1'b1) begin n_fail++; $display("FAIL out_vld_first got %b exp %b", ext_out_vld[0], 1'b1); end
        n_tests++; if (ext_out_data[15:0] !== 16'hBEEF) begin n_fail++; $display("FAIL out_data_first got %h exp %h", ext_out_data[15:0], 16'hBEEF); end
      end
      if (i == 3) begin
        n_tests++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL out_ovf_early got %b exp %b", err_ovf, 1'b0); end
      end
    end
    out_en = 1'b0;
    n_tests++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL out_ovf_set got %b exp %b", err_ovf, 1'b1); end
    ext_out_rdy = 2'b01;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ext_out_data[15:0] !== wr[i] || ext_out_vld[0] !== 1'b1) begin n_fail++; $display("FAIL out_drain%0d got %h/%b exp %h/1", i, ext_out_data[15:0], ext_out_vld[0], wr[i]); end
      step();
    end
    n_tests++; if (ext_out_vld[0] !== 1'b0) begin n_fail++; $display("FAIL out_vld_fall got %b exp %b", ext_out_vld[0], 1'b0); end
    n_tests++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL out_ovf_sticky got %b exp %b", err_ovf, 1'b1); end
    ext_out_rdy = 2'b00;
  endtask

  task automatic test_full_pop;
    logic [15:0] exp_w [4];
    exp_w = '{16'h0002, 16'h0003, 16'h0004, 16'hAAAA};
    do_reset();
    out_en = 1'b1; addr_out = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      io_out = 16'(i);
      step();
    end
    io_out = 16'hAAAA; ext_out_rdy = 2'b01;
    step();
    out_en = 1'b0;
    n_tests++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL fp_ovf got %b exp %b", err_ovf, 1'b0); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ext_out_data[15:0] !== exp_w[i] || ext_out_vld[0] !== 1'b1) begin n_fail++; $display("FAIL fp_drain%0d got %h/%b exp %h/1", i, ext_out_data[15:0], ext_out_vld[0], exp_w[i]); end
      step();
    end
    n_tests++; if (ext_out_vld[0] !== 1'b0) begin n_fail++; $display("FAIL fp_vld_fall got %b exp %b", ext_out_vld[0], 1'b0); end
    ext_out_rdy = 2'b00;
  endtask

  task automatic test_concurrent;
    do_reset();
    ext_in_vld = 2'b01;
    ext_in_data = {16'h0000, 16'hA001}; step();
    ext_in_data = {16'h0000, 16'hA002}; step();
    // read port 0, write output port 1, push input port 0, all on one edge
    addr_in = 1'b0; req_in = 1'b1;
    addr_out = 1'b1; out_en = 1'b1; io_out = 16'hC0DE;
    ext_in_data = {16'h0000, 16'hA003};
    step();
    clear_inputs();
    #1;
    n_tests++; if (io_in !== 16'hA002) begin n_fail++; $display("FAIL cc_head0 got %h exp %h", io_in, 16'hA002); end
    n_tests++; if (ext_out_vld !== 2'b10) begin n_fail++; $display("FAIL cc_vld got %b exp %b", ext_out_vld, 2'b10); end
    n_tests++; if (ext_out_data[31:16] !== 16'hC0DE) begin n_fail++; $display("FAIL cc_out1 got %h exp %h", ext_out_data[31:16], 16'hC0DE); end
    n_tests++; if (ext_in_rdy !== 2'b11) begin n_fail++; $display("FAIL cc_rdy got %b exp %b", ext_in_rdy, 2'b11); end
    addr_in = 1'b1;
    #1;
    n_tests++; if (io_in !== 16'h0) begin n_fail++; $display("FAIL cc_port1_empty got %h exp %h", io_in, 16'h0); end
    addr_in = 1'b0; req_in = 1'b1;
    step();
    n_tests++; if (io_in !== 16'hA003) begin n_fail++; $display("FAIL cc_head0_next got %h exp %h", io_in, 16'hA003); end
    step();
    req_in = 1'b0;
    n_tests++; if (io_in !== 16'h0) begin n_fail++; $display("FAIL cc_port0_empty got %h exp %h", io_in, 16'h0); end
    n_tests++; if (err_udf !== 1'b0) begin n_fail++; $display("FAIL cc_udf got %b exp %b", err_udf, 1'b0); end
  endtask

  task automatic test_random;
    logic [NUIOIN-1:0] er;
    logic [NUIOOU-1:0] ev;
    int hi;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // alternate filling-biased and draining-biased phases
      hi = ((c / 50) % 2 == 0) ? 3 : 1;
      for (int k = 0; k < NUIOIN; k++) begin
        ext_in_vld[k] = ($urandom_range(0, 3) < hi);
        ext_in_data[k*NUBITS +: NUBITS] = 16'($urandom);
      end
      for (int k = 0; k < NUIOOU; k++) ext_out_rdy[k] = ($urandom_range(0, 3) >= hi);
      req_in   = ($urandom_range(0, 3) >= hi);
      addr_in  = 1'($urandom_range(0, 1));
      out_en   = ($urandom_range(0, 3) < hi);
      addr_out = 1'($urandom_range(0, 1));
      io_out   = 16'($urandom);
      #1;
      er = exp_in_rdy();
      ev = exp_out_vld();
      n_tests++; if (io_in !== exp_io_in()) begin n_fail++; $display("FAIL rnd_io_in c=%0d got %h exp %h", c, io_in, exp_io_in()); end
      n_tests++; if (ext_in_rdy !== er) begin n_fail++; $display("FAIL rnd_in_rdy c=%0d got %b exp %b", c, ext_in_rdy, er); end
      n_tests++; if (ext_out_vld !== ev) begin n_fail++; $display("FAIL rnd_out_vld c=%0d got %b exp %b", c, ext_out_vld, ev); end
      for (int k = 0; k < NUIOOU; k++) begin
        if (out_exp_q[k].size() > 0) begin
          n_tests++;
          if (ext_out_data[k*NUBITS +: NUBITS] !== out_exp_q[k][0]) begin
            n_fail++; $display("FAIL rnd_out_data%0d c=%0d got %h exp %h", k, c, ext_out_data[k*NUBITS +: NUBITS], out_exp_q[k][0]);
          end
        end
      end
      n_tests++; if (itr !== m_itr) begin n_fail++; $display("FAIL rnd_itr c=%0d got %b exp %b", c, itr, m_itr); end
      n_tests++; if (err_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got %b exp %b", c, err_ovf, m_ovf); end
      n_tests++; if (err_udf !== m_udf) begin n_fail++; $display("FAIL rnd_udf c=%0d got %b exp %b", c, err_udf, m_udf); end
      step();
    end
    clear_inputs();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    test_reset();
    test_input_path();
    test_input_full();
    test_output_path();
    test_full_pop();
    test_concurrent();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
